// File: rtl/cu_multicycle.sv
// Multicycle control unit (FETCH/DECODE/EXEC/MEM/WB); each output is the registered decision of the previous cycle's state.
// Optional macro CU_BRANCH_UNSIGNED_EN enables BLTU/BGEU decoding with BrUn.
module cu_multicycle #(
  parameter int ALUOP_W = 4,
  parameter int ILEN    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ILEN-1:0]    I,
  input  logic               I_valid,
  input  logic               BrEq,
  input  logic               BrLt,
  input  logic               mem_ready,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [2:0]         ImmSel,
  output logic               ASel,
  output logic               BSel,
  output logic               BrUn,
  output logic               PCSel,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               wEn,
  output logic [1:0]         WBSel,
  output logic               mem_req,
  output logic               MemRW,
  output logic               illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b1001;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1110;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} stateT;

  stateT           state, stateNext;
  logic [ILEN-1:0] instrReg;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            altBit;
  logic            unusedBits;

  logic isR, isI, isLoad, isStore, isBranch, isJal, isLui, opLegal;
  logic [3:0] aluDecoded;
  logic [2:0] immDecoded;
  logic       branchLegal, branchTaken;

  logic [3:0] aluOpQ, aluOpNext;
  logic [2:0] immSelNext;
  logic [1:0] wbSelNext;
  logic aSelNext, bSelNext, pcSelNext, pcWriteNext, irWriteNext;
  logic wEnNext, memReqNext, memRwNext, illegalNext;
`ifdef CU_BRANCH_UNSIGNED_EN
  logic branchUnsigned, brUnNext;
`endif

  assign opcode     = instrReg[6:0];
  assign funct3     = instrReg[14:12];
  assign altBit     = instrReg[30];
  assign unusedBits = ^{instrReg[ILEN-1:31], instrReg[29:15], instrReg[11:7]};

  assign isR      = (opcode == OP_R);
  assign isI      = (opcode == OP_I);
  assign isLoad   = (opcode == OP_LOAD);
  assign isStore  = (opcode == OP_STORE);
  assign isBranch = (opcode == OP_BRANCH);
  assign isJal    = (opcode == OP_JAL);
  assign isLui    = (opcode == OP_LUI);
  assign opLegal  = isR | isI | isLoad | isStore | isBranch | isJal | isLui;

  assign ALUop = ALUOP_W'(aluOpQ);

  // Only R and I-ALU take their operation from funct3; everything else adds.
  always_comb begin
    aluDecoded = ALU_ADD;
    if (isR || isI) begin
      case (funct3)
        3'b000:  aluDecoded = (isR && altBit) ? ALU_SUB : ALU_ADD;
        3'b001:  aluDecoded = ALU_SLL;
        3'b010:  aluDecoded = ALU_SLT;
        3'b011:  aluDecoded = ALU_SLTU;
        3'b100:  aluDecoded = ALU_XOR;
        3'b101:  aluDecoded = altBit ? ALU_SRA : ALU_SRL;
        3'b110:  aluDecoded = ALU_OR;
        default: aluDecoded = ALU_AND;
      endcase
    end
  end

  always_comb begin
    immDecoded = 3'd0;
    if (isI || isLoad) immDecoded = 3'd1;
    else if (isStore)  immDecoded = 3'd2;
    else if (isBranch) immDecoded = 3'd3;
    else if (isLui)    immDecoded = 3'd4;
    else if (isJal)    immDecoded = 3'd5;
  end

  // Unsupported branch conditions are reported as illegal and never taken.
  always_comb begin
    branchLegal = 1'b1;
    branchTaken = 1'b0;
`ifdef CU_BRANCH_UNSIGNED_EN
    branchUnsigned = 1'b0;
`endif
    case (funct3)
      3'b000: branchTaken = BrEq;
      3'b001: branchTaken = !BrEq;
      3'b100: branchTaken = BrLt;
      3'b101: branchTaken = !BrLt;
`ifdef CU_BRANCH_UNSIGNED_EN
      3'b110: begin branchTaken = BrLt;  branchUnsigned = 1'b1; end
      3'b111: begin branchTaken = !BrLt; branchUnsigned = 1'b1; end
`endif
      default: branchLegal = 1'b0;
    endcase
  end

  always_comb begin
    stateNext   = state;
    aluOpNext   = 4'd0;
    immSelNext  = 3'd0;
    aSelNext    = 1'b0;
    bSelNext    = 1'b0;
    pcSelNext   = 1'b0;
    pcWriteNext = 1'b0;
    irWriteNext = 1'b0;
    wEnNext     = 1'b0;
    wbSelNext   = 2'd0;
    memReqNext  = 1'b0;
    memRwNext   = 1'b0;
    illegalNext = 1'b0;
`ifdef CU_BRANCH_UNSIGNED_EN
    brUnNext    = 1'b0;
`endif
    case (state)
      FETCH: begin
        if (I_valid) begin
          irWriteNext = 1'b1;
          stateNext   = DECODE;
        end
      end
      DECODE: begin
        if (opLegal) begin
          stateNext = EXEC;
        end else begin
          illegalNext = 1'b1;
          pcWriteNext = 1'b1;
          stateNext   = FETCH;
        end
      end
      EXEC: begin
        aluOpNext  = aluDecoded;
        immSelNext = immDecoded;
        aSelNext   = isBranch | isJal;
        bSelNext   = !isR;
        if (isBranch) begin
          pcWriteNext = 1'b1;
          pcSelNext   = branchLegal & branchTaken;
          illegalNext = !branchLegal;
`ifdef CU_BRANCH_UNSIGNED_EN
          brUnNext    = branchUnsigned;
`endif
          stateNext   = FETCH;
        end else if (isLoad || isStore) begin
          stateNext = MEM;
        end else begin
          pcSelNext = isJal;
          stateNext = WB;
        end
      end
      MEM: begin
        memReqNext = 1'b1;
        memRwNext  = isStore;
        if (mem_ready) begin
          if (isStore) begin
            pcWriteNext = 1'b1;
            stateNext   = FETCH;
          end else begin
            stateNext = WB;
          end
        end
      end
      WB: begin
        wEnNext     = 1'b1;
        pcWriteNext = 1'b1;
        pcSelNext   = isJal;
        wbSelNext   = isLoad ? 2'd1 : (isJal ? 2'd2 : 2'd0);
        stateNext   = FETCH;
      end
      default: stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      instrReg <= '0;
      aluOpQ   <= 4'd0;
      ImmSel   <= 3'd0;
      ASel     <= 1'b0;
      BSel     <= 1'b0;
      PCSel    <= 1'b0;
      PCWrite  <= 1'b0;
      IRWrite  <= 1'b0;
      wEn      <= 1'b0;
      WBSel    <= 2'd0;
      mem_req  <= 1'b0;
      MemRW    <= 1'b0;
      illegal  <= 1'b0;
`ifdef CU_BRANCH_UNSIGNED_EN
      BrUn     <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      if (state == FETCH && I_valid) instrReg <= I;
      aluOpQ  <= aluOpNext;
      ImmSel  <= immSelNext;
      ASel    <= aSelNext;
      BSel    <= bSelNext;
      PCSel   <= pcSelNext;
      PCWrite <= pcWriteNext;
      IRWrite <= irWriteNext;
      wEn     <= wEnNext;
      WBSel   <= wbSelNext;
      mem_req <= memReqNext;
      MemRW   <= memRwNext;
      illegal <= illegalNext;
`ifdef CU_BRANCH_UNSIGNED_EN
      BrUn    <= brUnNext;
`endif
    end
  end

`ifndef CU_BRANCH_UNSIGNED_EN
  assign BrUn = 1'b0;
`endif

endmodule

// File: tb/tb_cu_multicycle.sv
// Randomized bench for cu_multicycle; expected per-cycle control traces come from a cycle-timeline model of the instruction classes.
module tb_cu_multicycle;

  typedef struct packed {
    logic [3:0] aluOp;
    logic [2:0] immSel;
    logic       aSel;
    logic       bSel;
    logic       brUn;
    logic       pcSel;
    logic       pcWrite;
    logic       irWrite;
    logic       wEn;
    logic [1:0] wbSel;
    logic       memReq;
    logic       memRw;
    logic       illegal;
  } ctrlT;

  logic        clk;
  logic        rst_n;
  logic [31:0] I;
  logic        I_valid, BrEq, BrLt, mem_ready;
  logic [3:0]  ALUop;
  logic [2:0]  ImmSel;
  logic        ASel, BSel, BrUn, PCSel, PCWrite, IRWrite, wEn;
  logic [1:0]  WBSel;
  logic        mem_req, MemRW, illegal;

  ctrlT expTrace [0:31];
  ctrlT obsTrace [0:31];
  int   compared;
  int   failed;

  cu_multicycle #(.ALUOP_W(4), .ILEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .I(I), .I_valid(I_valid), .BrEq(BrEq), .BrLt(BrLt),
    .mem_ready(mem_ready), .ALUop(ALUop), .ImmSel(ImmSel), .ASel(ASel), .BSel(BSel),
    .BrUn(BrUn), .PCSel(PCSel), .PCWrite(PCWrite), .IRWrite(IRWrite), .wEn(wEn),
    .WBSel(WBSel), .mem_req(mem_req), .MemRW(MemRW), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic ctrlT snapshot();
    return {ALUop, ImmSel, ASel, BSel, BrUn, PCSel, PCWrite, IRWrite, wEn, WBSel, mem_req, MemRW, illegal};
  endfunction

  function automatic logic [31:0] randomInstr(input int cls);
    logic [31:0] r;
    r = $urandom;
    case (cls)
      0: r[6:0] = 7'b0110011;
      1: r[6:0] = 7'b0010011;
      2: r[6:0] = 7'b0000011;
      3: r[6:0] = 7'b0100011;
      4: r[6:0] = 7'b1100011;
      5: r[6:0] = 7'b1101111;
      6: r[6:0] = 7'b0110111;
      default: r[1:0] = 2'b00;
    endcase
    return r;
  endfunction

  // Cycle 1 is the cycle after the accepting edge; cycle len is the last with activity.
  task automatic modelTrace(input logic [31:0] ins, input logic eq, input logic lt,
                            input int waits, output int len);
    logic [6:0] op;
    logic [2:0] f3;
    logic       isR, isI, isLd, isSt, isBr, isJal, isLui;
    logic       taken, valid, uns;
    logic [3:0] alu;
    int         n;
    op = ins[6:0];
    f3 = ins[14:12];
    isR = (op == 7'b0110011); isI = (op == 7'b0010011); isLd = (op == 7'b0000011);
    isSt = (op == 7'b0100011); isBr = (op == 7'b1100011); isJal = (op == 7'b1101111);
    isLui = (op == 7'b0110111);
    for (int i = 0; i < 32; i++) expTrace[i] = '0;
    expTrace[1].irWrite = 1'b1;
    if (!(isR || isI || isLd || isSt || isBr || isJal || isLui)) begin
      expTrace[2].illegal = 1'b1;
      expTrace[2].pcWrite = 1'b1;
      len = 2;
      return;
    end
    alu = 4'b1001;
    if (isR || isI) begin
      case (f3)
        3'd0: alu = (isR && ins[30]) ? 4'b0001 : 4'b1001;
        3'd1: alu = 4'b0101;
        3'd2: alu = 4'b0110;
        3'd3: alu = 4'b0111;
        3'd4: alu = 4'b0010;
        3'd5: alu = ins[30] ? 4'b1110 : 4'b1101;
        3'd6: alu = 4'b0011;
        default: alu = 4'b0100;
      endcase
    end
    expTrace[3].aluOp  = alu;
    expTrace[3].immSel = isR ? 3'd0 : (isI || isLd) ? 3'd1 : isSt ? 3'd2 :
                         isBr ? 3'd3 : isLui ? 3'd4 : 3'd5;
    expTrace[3].aSel   = isBr || isJal;
    expTrace[3].bSel   = !isR;
    if (isBr) begin
      valid = 1'b1; taken = 1'b0; uns = 1'b0;
      case (f3)
        3'd0: taken = eq;
        3'd1: taken = !eq;
        3'd4: taken = lt;
        3'd5: taken = !lt;
`ifdef CU_BRANCH_UNSIGNED_EN
        3'd6: begin taken = lt;  uns = 1'b1; end
        3'd7: begin taken = !lt; uns = 1'b1; end
`endif
        default: valid = 1'b0;
      endcase
      expTrace[3].pcWrite = 1'b1;
      expTrace[3].pcSel   = taken && valid;
      expTrace[3].illegal = !valid;
      expTrace[3].brUn    = uns;
      len = 3;
    end else if (isLd || isSt) begin
      n = waits + 1;
      for (int c = 4; c <= 3 + n; c++) begin
        expTrace[c].memReq = 1'b1;
        expTrace[c].memRw  = isSt;
      end
      if (isSt) begin
        expTrace[3 + n].pcWrite = 1'b1;
        len = 3 + n;
      end else begin
        expTrace[4 + n].wEn     = 1'b1;
        expTrace[4 + n].pcWrite = 1'b1;
        expTrace[4 + n].wbSel   = 2'd1;
        len = 4 + n;
      end
    end else begin
      expTrace[3].pcSel   = isJal;
      expTrace[4].wEn     = 1'b1;
      expTrace[4].pcWrite = 1'b1;
      expTrace[4].pcSel   = isJal;
      expTrace[4].wbSel   = isJal ? 2'd2 : 2'd0;
      len = 4;
    end
  endtask

  // Presents one instruction, strobes mem_ready at cycle 3+waits and records n cycles of outputs.
  task automatic applyStimulus(input logic [31:0] ins, input logic eq, input logic lt,
                               input int waits, input int n);
    @(negedge clk);
    I = ins; I_valid = 1'b1; BrEq = eq; BrLt = lt; mem_ready = 1'b0;
    @(posedge clk); #1;
    I_valid = 1'b0;
    I = $urandom;
    for (int k = 1; k <= n; k++) begin
      mem_ready = (k == 3 + waits);
      obsTrace[k] = snapshot();
      if (k < n) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    ctrlT s;
    int   len;
    rst_n = 1'b0; I = '0; I_valid = 1'b0; BrEq = 1'b0; BrLt = 1'b0; mem_ready = 1'b0;
    #12;
    s = snapshot();
    compared++;
    if (s !== '0) begin failed++; $display("[TB] FAIL reset_outputs: got %b expected %b", s, 19'd0); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); I = 32'h003100B3; I_valid = 1'b1;
    @(posedge clk); #1 I_valid = 1'b0;
    compared++;
    if (IRWrite !== 1'b1) begin failed++; $display("[TB] FAIL reset_prefetch_irwrite: got %b expected 1", IRWrite); end
    #2 rst_n = 1'b0;
    #1 s = snapshot();
    compared++;
    if (s !== '0) begin failed++; $display("[TB] FAIL reset_async: got %b expected %b", s, 19'd0); end
    @(posedge clk); #1 rst_n = 1'b1;
    modelTrace(32'h003100B3, 1'b0, 1'b0, 99, len);
    applyStimulus(32'h003100B3, 1'b0, 1'b0, 99, len + 1);
    for (int k = 1; k <= len + 1; k++) begin
      compared++;
      if (obsTrace[k] !== expTrace[k]) begin
        failed++;
        $display("[TB] FAIL reset_first_fetch cycle %0d: got %b expected %b", k, obsTrace[k], expTrace[k]);
      end
    end
  endtask

  task automatic test_alu;
    logic [31:0] ins;
    logic        eq, lt;
    int          len;
    for (int t = 0; t < 12; t++) begin
      ins = (t == 0) ? 32'h003100B3 : randomInstr((t % 4 == 3) ? 5 + (t % 2) : t % 2);
      eq = 1'($urandom_range(0, 1));
      lt = 1'($urandom_range(0, 1));
      modelTrace(ins, eq, lt, 99, len);
      applyStimulus(ins, eq, lt, 99, len + 1);
      for (int k = 1; k <= len + 1; k++) begin
        compared++;
        if (obsTrace[k] !== expTrace[k]) begin
          failed++;
          $display("[TB] FAIL alu %h cycle %0d: got %b expected %b", ins, k, obsTrace[k], expTrace[k]);
        end
      end
    end
  endtask

  task automatic test_branch;
    logic [31:0] ins;
    logic        eq, lt;
    int          len;
    for (int t = 0; t < 16; t++) begin
      eq = 1'($urandom_range(0, 1));
      lt = 1'($urandom_range(0, 1));
      case (t)
        0: begin ins = 32'h00208463; eq = 1'b1; end
        1: begin ins = 32'h00208463; eq = 1'b0; end
        2: begin ins = 32'h0020E463; lt = 1'b1; end
        3: begin ins = 32'h0020F463; lt = 1'b0; end
        default: ins = randomInstr(4);
      endcase
      modelTrace(ins, eq, lt, 99, len);
      applyStimulus(ins, eq, lt, 99, len + 1);
      for (int k = 1; k <= len + 1; k++) begin
        compared++;
        if (obsTrace[k] !== expTrace[k]) begin
          failed++;
          $display("[TB] FAIL branch %h eq=%b lt=%b cycle %0d: got %b expected %b", ins, eq, lt, k, obsTrace[k], expTrace[k]);
        end
      end
    end
  endtask

  task automatic test_load_store;
    logic [31:0] ins;
    int          waits, len;
    for (int t = 0; t < 10; t++) begin
      case (t)
        0: begin ins = 32'h0000A083; waits = 3; end
        1: begin ins = 32'h0020A023; waits = 0; end
        2: begin ins = 32'h0000A083; waits = 0; end
        default: begin ins = randomInstr(2 + (t % 2)); waits = $urandom_range(0, 5); end
      endcase
      modelTrace(ins, 1'b0, 1'b0, waits, len);
      applyStimulus(ins, 1'b0, 1'b0, waits, len + 1);
      for (int k = 1; k <= len + 1; k++) begin
        compared++;
        if (obsTrace[k] !== expTrace[k]) begin
          failed++;
          $display("[TB] FAIL mem %h waits=%0d cycle %0d: got %b expected %b", ins, waits, k, obsTrace[k], expTrace[k]);
        end
      end
    end
  endtask

  task automatic test_illegal;
    logic [31:0] ins;
    int          len;
    for (int t = 0; t < 6; t++) begin
      ins = (t == 0) ? 32'h0000007F : randomInstr(7);
      modelTrace(ins, 1'b0, 1'b0, 99, len);
      applyStimulus(ins, 1'b0, 1'b0, 99, len + 1);
      for (int k = 1; k <= len + 1; k++) begin
        compared++;
        if (obsTrace[k] !== expTrace[k]) begin
          failed++;
          $display("[TB] FAIL illegal %h cycle %0d: got %b expected %b", ins, k, obsTrace[k], expTrace[k]);
        end
      end
    end
  endtask

  // The next instruction is presented in the very cycle the previous one returns to FETCH.
  task automatic test_back_to_back;
    logic [31:0] ins;
    logic        eq, lt;
    int          waits, len, n;
    for (int t = 0; t < 12; t++) begin
      ins   = randomInstr($urandom_range(0, 7));
      eq    = 1'($urandom_range(0, 1));
      lt    = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 3);
      modelTrace(ins, eq, lt, waits, len);
      n = (t == 11) ? len + 1 : len;
      applyStimulus(ins, eq, lt, waits, n);
      for (int k = 1; k <= n; k++) begin
        compared++;
        if (obsTrace[k] !== expTrace[k]) begin
          failed++;
          $display("[TB] FAIL back_to_back %h cycle %0d: got %b expected %b", ins, k, obsTrace[k], expTrace[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_mem;
    ctrlT s;
    int   len;
    @(negedge clk);
    I = 32'h0020A023; I_valid = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1 I_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    compared++;
    if (mem_req !== 1'b1) begin failed++; $display("[TB] FAIL mid_mem_req: got %b expected 1", mem_req); end
    #3 rst_n = 1'b0;
    #1 s = snapshot();
    compared++;
    if (s !== '0) begin failed++; $display("[TB] FAIL mid_mem_reset: got %b expected %b", s, 19'd0); end
    mem_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      s = snapshot();
      compared++;
      if (s !== '0) begin failed++; $display("[TB] FAIL stale_mem_ready %0d: got %b expected %b", c, s, 19'd0); end
    end
    modelTrace(32'h003100B3, 1'b0, 1'b0, 99, len);
    applyStimulus(32'h003100B3, 1'b0, 1'b0, 99, len + 1);
    for (int k = 1; k <= len + 1; k++) begin
      compared++;
      if (obsTrace[k] !== expTrace[k]) begin
        failed++;
        $display("[TB] FAIL after_mem_reset cycle %0d: got %b expected %b", k, obsTrace[k], expTrace[k]);
      end
    end
  endtask

  initial begin
    compared = 0;
    failed   = 0;
    test_reset;
    test_alu;
    test_branch;
    test_load_store;
    test_illegal;
    test_back_to_back;
    test_reset_mid_mem;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
